// File: rtl/alu_mdu_seq_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the EX-stage ALU/MDU.
// No ports; imported by the interface, divider and top.
package alu_pkg;

  // Op encoding shared with the single-cycle datapath ALU.
  typedef enum logic [3:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_ADD   = 4'd2,
    ALU_MUL   = 4'd3,
    ALU_MULHU = 4'd4,
    ALU_DIVU  = 4'd5,
    ALU_SUB   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_REMU  = 4'd9,
    ALU_NOR   = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  // Ops that run through the iterative multiplier or divider.
  function automatic logic is_iterative(input logic [3:0] op);
    return op inside {ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU};
  endfunction

  function automatic logic is_divide(input logic [3:0] op);
    return op inside {ALU_DIVU, ALU_REMU};
  endfunction

endpackage

// File: rtl/alu_mdu_seq_if.sv
// Request/response bundle between the EX pipeline (master) and alu_mdu_seq (slave).
// Signals: in_valid/in_ready/src1/src2/op_sel (request), out_valid/out_ready/
// result/zero (response), busy (multi-cycle op in flight).
interface alu_mdu_seq_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [3:0]      op_sel;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, src1, src2, op_sel, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, src1, src2, op_sel, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_mdu_seq_divider.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock.
// Ports: clk, rst (async, active-high); start loads dividend/divisor;
// done_c marks the final step, with quotient_c/remainder_c holding that step's
// results (valid only while done_c is high).
module seq_divider #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done_c,
  output logic [XLEN-1:0] quotient_c,
  output logic [XLEN-1:0] remainder_c
);
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  dvs_q;
  logic [XLEN:0]    shifted;
  logic [XLEN-1:0]  diff;
  logic             fits;

  // One restoring step. A zero divisor always "fits", so the quotient fills
  // with ones and the remainder ends up equal to the dividend.
  always_comb begin
    shifted     = {rem_q, quo_q[XLEN-1]};
    fits        = shifted >= {1'b0, dvs_q};
    diff        = shifted[XLEN-1:0] - dvs_q;
    remainder_c = fits ? diff : shifted[XLEN-1:0];
    quotient_c  = {quo_q[XLEN-2:0], fits};
    done_c      = run_q && (cnt_q == CNT_W'(XLEN - 1));
  end

  // Iteration state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (run_q) begin
      quo_q <= quotient_c;
      rem_q <= remainder_c;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_c) run_q <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_mdu_seq.sv
// EX-stage ALU with iterative unsigned multiply/divide behind a valid/ready handshake.
// Ports: clk, rst (async, active-high), bus (alu_mdu_seq_if.slave): request
// in_valid/in_ready/src1/src2/op_sel, response out_valid/out_ready/result/zero,
// busy while a multiply or divide iterates.
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic           clk,
  input  logic           rst,
  alu_mdu_seq_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  mdu_state_e        state_q, state_d;
  logic [3:0]        op_q;
  logic [XLEN-1:0]   result_q;
  logic              zero_q;
  logic [XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              in_ready_c;
  logic              accept;
  logic              mul_last;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN-1:0]   mul_res;
  logic              div_start;
  logic              div_done_c;
  logic [XLEN-1:0]   div_quo_c;
  logic [XLEN-1:0]   div_rem_c;

  seq_divider #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (div_start),
    .dividend    (bus.src1),
    .divisor     (bus.src2),
    .done_c      (div_done_c),
    .quotient_c  (div_quo_c),
    .remainder_c (div_rem_c)
  );

  // Next state and handshake decode.
  always_comb begin
    state_d    = state_q;
    in_ready_c = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    accept     = bus.in_valid && in_ready_c;
    mul_last   = (state_q == MUL) && (cnt_q == CNT_W'(XLEN - 1));
    div_start  = accept && is_divide(bus.op_sel);
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (!is_iterative(bus.op_sel))  state_d = DONE;
          else if (is_divide(bus.op_sel)) state_d = DIV;
          else                            state_d = MUL;
        end else if ((state_q == DONE) && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      MUL:     if (mul_last)   state_d = DONE;
      DIV:     if (div_done_c) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Single-cycle ops, evaluated on the live operands at accept.
  always_comb begin
    alu_res = '0;
    case (bus.op_sel)
      ALU_AND:  alu_res = bus.src1 & bus.src2;
      ALU_OR:   alu_res = bus.src1 | bus.src2;
      ALU_ADD:  alu_res = bus.src1 + bus.src2;
      ALU_SUB:  alu_res = bus.src1 - bus.src2;
      ALU_SLTU: alu_res = XLEN'(bus.src1 < bus.src2);
      ALU_SLT:  alu_res = XLEN'($signed(bus.src1) < $signed(bus.src2));
      ALU_NOR:  alu_res = ~(bus.src1 | bus.src2);
      default:  alu_res = '0;
    endcase
  end

  // Shift-add step: add into the upper half, then shift the whole
  // accumulator right so the product settles into acc after XLEN steps.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    acc_d   = {mul_sum, acc_q[XLEN-1:1]};
    mul_res = (op_q == ALU_MULHU) ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
  end

  // Operand capture, multiplier iteration and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        op_q <= bus.op_sel;
        if (!is_iterative(bus.op_sel)) begin
          result_q <= alu_res;
          zero_q   <= (alu_res == '0);
        end else if (!is_divide(bus.op_sel)) begin
          mcand_q  <= bus.src1;
          mplier_q <= bus.src2;
          acc_q    <= '0;
          cnt_q    <= '0;
        end
      end
      if (state_q == MUL) begin
        acc_q    <= acc_d;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (mul_last) begin
          result_q <= mul_res;
          zero_q   <= (mul_res == '0);
        end
      end
      if ((state_q == DIV) && div_done_c) begin
        result_q <= (op_q == ALU_REMU) ? div_rem_c : div_quo_c;
        zero_q   <= (((op_q == ALU_REMU) ? div_rem_c : div_quo_c) == '0);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == MUL) || (state_q == DIV);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Self-checking bench for alu_mdu_seq at XLEN=64 and XLEN=8 against an
// arithmetic reference model.
module tb_alu_mdu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_mdu_seq_if #(.XLEN(64)) b64 ();
  alu_mdu_seq_if #(.XLEN(8))  b8 ();

  alu_mdu_seq #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(b64));
  alu_mdu_seq #(.XLEN(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: plain arithmetic on w-bit unsigned values.
  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input int w);
    logic [63:0]  m, sb, x, y, r;
    logic [127:0] p;
    m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    sb = 64'd1 << (w - 1);
    x  = a & m;
    y  = b & m;
    p  = {64'd0, x} * {64'd0, y};
    case (op)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = x + y;
      4'd6:  r = x - y;
      4'd7:  r = 64'(x < y);
      4'd8:  r = 64'((x ^ sb) < (y ^ sb));
      4'd12: r = ~(x | y);
      4'd3:  r = p[63:0];
      4'd4:  r = 64'(p >> w);
      4'd5:  r = (y == 64'd0) ? m : x / y;
      4'd9:  r = (y == 64'd0) ? x : x % y;
      default: r = 64'd0;
    endcase
    return r & m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic v, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (w8) begin
      b8.in_valid = v; b8.op_sel = op; b8.src1 = a[7:0]; b8.src2 = b[7:0];
    end else begin
      b64.in_valid = v; b64.op_sel = op; b64.src1 = a; b64.src2 = b;
    end
  endtask

  task automatic sample(input bit w8, output logic ir, output logic ov, output logic bz,
                        output logic zr, output logic [63:0] res);
    if (w8) begin
      ir = b8.in_ready; ov = b8.out_valid; bz = b8.busy; zr = b8.zero; res = 64'(b8.result);
    end else begin
      ir = b64.in_ready; ov = b64.out_valid; bz = b64.busy; zr = b64.zero; res = b64.result;
    end
  endtask

  // Issue one op with out_ready high and check result, zero, latency and busy time.
  task automatic run_op(input string tag, input bit w8, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b);
    int          w, lat, busy_n, n;
    logic [63:0] exp, res;
    logic        ir, ov, bz, zr;
    bit          iter;
    w    = w8 ? 8 : 64;
    exp  = ref_model(op, a, b, w);
    iter = (op == 4'd3) || (op == 4'd4) || (op == 4'd5) || (op == 4'd9);
    drive(w8, 1'b1, op, a, b);
    n = 0;
    sample(w8, ir, ov, bz, zr, res);
    while (!ir && n < 300) begin tick(); n++; sample(w8, ir, ov, bz, zr, res); end
    chk($sformatf("%s in_ready", tag), 64'(ir), 64'd1);
    tick();
    drive(w8, 1'b0, ~op, ~a, ~b);
    lat = 1; busy_n = 0;
    sample(w8, ir, ov, bz, zr, res);
    while (!ov && lat < 300) begin
      if (bz) busy_n++;
      tick(); lat++;
      sample(w8, ir, ov, bz, zr, res);
    end
    chk($sformatf("%s result", tag), res, exp);
    chk($sformatf("%s zero", tag), 64'(zr), 64'(exp == 64'd0));
    chk($sformatf("%s latency", tag), 64'(lat), iter ? 64'(w + 1) : 64'd1);
    if (iter) chk($sformatf("%s busy cycles", tag), 64'(busy_n), 64'(w));
    tick();
  endtask

  initial begin
    int          n;
    logic [3:0]  op;
    logic [63:0] a, b;
    drive(1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 4'd0, 64'd0, 64'd0);
    b64.out_ready = 1'b1;
    b8.out_ready  = 1'b1;

    // Reset state.
    tick(); tick();
    chk("reset out_valid", 64'(b64.out_valid), 64'd0);
    chk("reset result", b64.result, 64'd0);
    chk("reset zero", 64'(b64.zero), 64'd1);
    chk("reset busy", 64'(b64.busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    chk("post-reset in_ready", 64'(b64.in_ready), 64'd1);
    chk("post-reset in_ready w8", 64'(b8.in_ready), 64'd1);

    // Reset in the middle of a divide.
    drive(1'b0, 1'b1, ALU_DIVU, 64'd1000, 64'd3);
    tick();
    drive(1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
    repeat (10) tick();
    chk("mid-div busy", 64'(b64.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst mid-div out_valid", 64'(b64.out_valid), 64'd0);
    chk("rst mid-div result", b64.result, 64'd0);
    chk("rst mid-div zero", 64'(b64.zero), 64'd1);
    chk("rst mid-div busy", 64'(b64.busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    chk("rst mid-div in_ready", 64'(b64.in_ready), 64'd1);
    run_op("add 5+7", 1'b0, ALU_ADD, 64'd5, 64'd7);

    // Back-to-back single-cycle stream.
    drive(1'b0, 1'b1, ALU_SUB, 64'd3, 64'd3);
    chk("stream in_ready sub", 64'(b64.in_ready), 64'd1);
    tick();
    chk("stream sub result", b64.result, 64'd0);
    chk("stream sub zero", 64'(b64.zero), 64'd1);
    drive(1'b0, 1'b1, ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk("stream in_ready slt", 64'(b64.in_ready), 64'd1);
    tick();
    chk("stream slt result", b64.result, 64'd1);
    chk("stream slt out_valid", 64'(b64.out_valid), 64'd1);
    drive(1'b0, 1'b1, ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk("stream in_ready sltu", 64'(b64.in_ready), 64'd1);
    tick();
    chk("stream sltu result", b64.result, 64'd0);
    chk("stream sltu zero", 64'(b64.zero), 64'd1);
    drive(1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
    tick();
    chk("stream drained out_valid", 64'(b64.out_valid), 64'd0);

    // Directed multiply / divide corners.
    run_op("mul ones*2", 1'b0, ALU_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    run_op("mulhu ones*2", 1'b0, ALU_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    run_op("divu 100/7", 1'b0, ALU_DIVU, 64'd100, 64'd7);
    run_op("remu 100/7", 1'b0, ALU_REMU, 64'd100, 64'd7);
    run_op("divu by 0", 1'b0, ALU_DIVU, 64'h1234, 64'd0);
    run_op("remu by 0", 1'b0, ALU_REMU, 64'h1234, 64'd0);
    run_op("nor", 1'b0, ALU_NOR, 64'h0F0F, 64'hF000_0000_0000_00F0);

    // Backpressure after a multiply completes.
    b64.out_ready = 1'b0;
    drive(1'b0, 1'b1, ALU_MUL, 64'd3, 64'd5);
    tick();
    drive(1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
    n = 0;
    while (!b64.out_valid && n < 300) begin tick(); n++; end
    chk("bp mul result", b64.result, 64'd15);
    drive(1'b0, 1'b1, ALU_ADD, 64'd1, 64'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp in_ready", 64'(b64.in_ready), 64'd0);
      tick();
      chk("bp held result", b64.result, 64'd15);
      chk("bp out_valid", 64'(b64.out_valid), 64'd1);
    end
    b64.out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 64'(b64.in_ready), 64'd1);
    tick();
    chk("bp add result", b64.result, 64'd3);
    chk("bp add out_valid", 64'(b64.out_valid), 64'd1);
    drive(1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
    tick();

    // Narrow datapath.
    run_op("w8 mul 15*17", 1'b1, ALU_MUL, 64'd15, 64'd17);
    run_op("w8 mulhu 15*17", 1'b1, ALU_MULHU, 64'd15, 64'd17);
    run_op("w8 op13", 1'b1, 4'd13, 64'd5, 64'd3);
    run_op("w8 slt", 1'b1, ALU_SLT, 64'h80, 64'h7F);
    run_op("w8 divu", 1'b1, ALU_DIVU, 64'd250, 64'd9);

    // Randomized ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 9));
      run_op($sformatf("rand64 #%0d op%0d", i, op), 1'b0, op, a, b);
    end
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 64'($urandom_range(0, 255));
      b  = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 2));
      run_op($sformatf("rand8 #%0d op%0d", i, op), 1'b1, op, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
